sd_wb_reg_sequencer: RTL and testbench

Table-driven Wishbone master that programs an SD controller's register file after reset, then reads registers back to check them.
It generalises the hard-coded SD-bus init/verify sequencer:
- entry count, address width and data width are parameters;
- the register table is a port input;
- readback is masked per entry;
- failed checks are retried;
- a stalled slave is caught by an ack watchdog;
- success and failure are reported with status outputs.

It sits between top-level SD bring-up logic and the sdc_controller slave port.

---
 rtl/sd_wb_seq_pkg.sv | 9 +
 rtl/wb_ack_watchdog.sv | 18 +
 rtl/sd_wb_reg_sequencer.sv | 151 +++++++++++++++
 tb/tb_sd_wb_reg_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wb_seq_pkg.sv
// sd_wb_seq_pkg: state encoding and error codes for the SD register sequencer
package sd_wb_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_RD_REQ, S_GAP, S_CHECK, S_DONE, S_FAIL
  } state_e;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
endpackage

// File: rtl/wb_ack_watchdog.sv
// wb_ack_watchdog: pulses timeout on the ACK_TIMEOUT-th strobe cycle without ack
module wb_ack_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stb,
  input  logic ack,
  output logic timeout
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n || !stb || ack) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
  assign timeout = stb && !ack && (cnt_q == CW'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/sd_wb_reg_sequencer.sv
// sd_wb_reg_sequencer: table-driven Wishbone init/verify sequencer for the SD controller
module sd_wb_reg_sequencer
  import sd_wb_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 12,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 255,
  parameter int MAX_RETRIES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_ENTRIES*ADDR_W-1:0] cfg_addr,
  input  logic [NUM_ENTRIES*DATA_W-1:0] cfg_data,
  input  logic [NUM_ENTRIES*DATA_W-1:0] cfg_mask,
  output logic [ADDR_W-1:0]             wb_adr_o,
  output logic [DATA_W-1:0]             wb_dat_o,
  input  logic [DATA_W-1:0]             wb_dat_i,
  output logic [DATA_W/8-1:0]           wb_sel_o,
  output logic                          wb_we_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [5:0]                    err_index,
  output logic [3:0]                    retry_cnt
);
  state_e            state_q, state_d;
  logic [6:0]        idx_q, idx_d, fidx;
  logic              rd_q, rd_d, found, timeout, cyc;
  logic [DATA_W-1:0] rdat_q, rdat_d, cur_data, cur_mask;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        retry_q, retry_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [5:0]        eidx_q, eidx_d;
  // Selects the current entry and finds the first verify entry at or after idx_q.
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    cur_mask = '0;
    found    = 1'b0;
    fidx     = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (idx_q == 7'(k)) begin
        cur_addr = cfg_addr[k*ADDR_W +: ADDR_W];
        cur_data = cfg_data[k*DATA_W +: DATA_W];
        cur_mask = cfg_mask[k*DATA_W +: DATA_W];
      end
      if (int'(idx_q) <= k && |cfg_mask[k*DATA_W +: DATA_W]) begin
        found = 1'b1;
        fidx  = 7'(k);
      end
    end
  end
  wb_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wdog (
    .clk(clk), .reset_n(reset_n), .stb(cyc), .ack(wb_ack_i), .timeout(timeout)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    rdat_d  = rdat_q;
    retry_d = retry_q;
    err_d   = err_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WR_REQ;
        idx_d   = '0;
        rd_d    = 1'b0;
        retry_d = '0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        eidx_d  = '0;
      end
      S_WR_REQ, S_RD_REQ: if (wb_ack_i) begin
        rdat_d  = wb_dat_i;
        state_d = rd_q ? S_CHECK : S_GAP;
        if (!rd_q) begin
          rd_d  = idx_q == 7'(NUM_ENTRIES - 1);
          idx_d = rd_d ? 7'd0 : idx_q + 7'd1;
        end
      end else if (timeout) begin
        state_d = S_FAIL;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        eidx_d  = idx_q[5:0];
      end
      // GAP idx_q points at the next write, or at the search start for the next read.
      S_GAP: begin
        state_d = !rd_q ? S_WR_REQ : found ? S_RD_REQ : S_DONE;
        idx_d   = rd_q ? fidx : idx_q;
      end
      S_CHECK: if (((rdat_q ^ cur_data) & cur_mask) == '0) begin
        state_d = S_GAP;
        idx_d   = idx_q + 7'd1;
      end else if (retry_q < 4'(MAX_RETRIES)) begin
        state_d = S_GAP;
        retry_d = retry_q + 4'd1;
        idx_d   = '0;
        rd_d    = 1'b0;
      end else begin
        state_d = S_FAIL;
        err_d   = 1'b1;
        code_d  = ERR_MISMATCH;
        eidx_d  = idx_q[5:0];
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      rdat_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      rdat_q  <= rdat_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
    end
  end
  assign cyc       = state_q == S_WR_REQ || state_q == S_RD_REQ;
  assign wb_cyc_o  = cyc;
  assign wb_stb_o  = cyc;
  assign wb_we_o   = state_q == S_WR_REQ;
  assign wb_adr_o  = cyc ? cur_addr : '0;
  assign wb_dat_o  = wb_we_o ? cur_data : '0;
  assign wb_sel_o  = {(DATA_W/8){cyc}};
  assign busy      = cyc || state_q == S_GAP || state_q == S_CHECK;
  assign done      = state_q == S_DONE;
  assign error     = err_q;
  assign err_code  = code_q;
  assign err_index = eidx_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_sd_wb_reg_sequencer.sv
// tb_sd_wb_reg_sequencer: randomized scoreboard bench with an echo Wishbone slave
module tb_sd_wb_reg_sequencer;
  localparam int N = 4, AW = 8, DW = 32, TO = 8, MR = 2;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [N*AW-1:0] cfg_addr;
  logic [N*DW-1:0] cfg_data, cfg_mask;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i = '0;
  logic [DW/8-1:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i = 1'b0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [5:0] err_index;
  logic [3:0] retry_cnt;

  logic [AW-1:0] t_addr[N];
  logic [DW-1:0] t_data[N], t_mask[N];
  logic [DW-1:0] mem[256];
  int corrupt_idx = 0, corrupt_left = 0, nack_idx = 0;
  bit nack_en = 1'b0;

  typedef struct packed {logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; logic to;} acc_t;
  typedef struct packed {logic dn; logic er; logic [1:0] code; logic [5:0] idx; logic [3:0] rc;} out_t;
  acc_t acc_q[$];
  out_t out_q[$];
  int errors = 0, checks = 0;

  sd_wb_reg_sequencer #(.NUM_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .err_index(err_index), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cfg_addr[i*AW +: AW] = t_addr[i];
      cfg_data[i*DW +: DW] = t_data[i];
      cfg_mask[i*DW +: DW] = t_mask[i];
    end
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: walks the table by the sequencer's rules and lists every bus access and the final outcome.
  task automatic expect_run();
    int retries = 0, cl = corrupt_left;
    bit fin = 1'b0, restart;
    logic [DW-1:0] rd;
    while (!fin) begin
      restart = 1'b0;
      for (int e = 0; e < N && !fin; e++) begin
        if (nack_en && e == nack_idx) begin
          acc_q.push_back('{1'b1, t_addr[e], t_data[e], 1'b1});
          out_q.push_back('{1'b0, 1'b1, 2'd1, 6'(e), 4'(retries)});
          fin = 1'b1;
        end else acc_q.push_back('{1'b1, t_addr[e], t_data[e], 1'b0});
      end
      for (int e = 0; e < N && !fin && !restart; e++) begin
        if (t_mask[e] != '0) begin
          rd = t_data[e];
          if (cl > 0 && e == corrupt_idx) begin
            rd = rd ^ 32'd1;
            cl--;
          end
          acc_q.push_back('{1'b0, t_addr[e], '0, 1'b0});
          if (((rd ^ t_data[e]) & t_mask[e]) != '0) begin
            if (retries < MR) begin
              retries++;
              restart = 1'b1;
            end else begin
              out_q.push_back('{1'b0, 1'b1, 2'd2, 6'(e), 4'(retries)});
              fin = 1'b1;
            end
          end
        end
      end
      if (!fin && !restart) begin
        out_q.push_back('{1'b1, 1'b0, 2'd0, 6'd0, 4'(retries)});
        fin = 1'b1;
      end
    end
  endtask

  // Echo slave: acks on the 2nd strobe cycle, optionally corrupts or withholds ack.
  int scnt_s = 0;
  initial forever begin
    @(negedge clk);
    wb_dat_i = $urandom;
    if (!reset_n || !wb_stb_o) begin
      scnt_s = 0;
      wb_ack_i = 1'b0;
    end else begin
      scnt_s++;
      wb_ack_i = scnt_s == 2 && !(nack_en && wb_we_o && wb_adr_o == t_addr[nack_idx]);
      if (wb_ack_i && wb_we_o) mem[wb_adr_o] = wb_dat_o;
      else if (wb_ack_i) begin
        wb_dat_i = mem[wb_adr_o];
        if (corrupt_left > 0 && wb_adr_o == t_addr[corrupt_idx]) begin
          wb_dat_i = wb_dat_i ^ 32'd1;
          corrupt_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completed or timed-out access and on every run end.
  int scnt_m = 0;
  bit prev_busy = 1'b0, prev_done = 1'b0;
  logic [AW+DW:0] sv;
  logic [DW/8-1:0] sv_sel;
  task automatic cmp_acc(input logic to);
    acc_t e;
    if (acc_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL access: unexpected access %h", {sv, to});
    end else begin
      e = acc_q.pop_front();
      check("access", {sv, to}, e);
      check("stb_len", 64'(scnt_m), e.to ? 64'(TO) : 64'd2);
      check("sel", 64'(sv_sel), 64'hF);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset_n) begin
      scnt_m = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_pulse", 64'(done), 64'd0);
      if (wb_stb_o) begin
        scnt_m++;
        sv = {wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : '0};
        sv_sel = wb_sel_o;
        if (wb_ack_i) begin
          cmp_acc(1'b0);
          scnt_m = 0;
        end
      end else if (scnt_m > 0) begin
        cmp_acc(1'b1);
        scnt_m = 0;
      end
      if (prev_busy && !busy) begin
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL outcome: unexpected run end");
        end else check("outcome", {done, error, err_code, err_index, retry_cnt}, out_q.pop_front());
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic rand_table();
    bit dup;
    for (int i = 0; i < N; i++) begin
      do begin
        t_addr[i] = AW'($urandom);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (t_addr[j] == t_addr[i]) dup = 1'b1;
      end while (dup);
      t_data[i] = $urandom;
      t_mask[i] = '1;
    end
  endtask

  task automatic run(input int poke);
    int c;
    expect_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 3000; c++) begin
      if (!busy) break;
      start = (poke > 0 && c == poke);
      @(negedge clk);
    end
    start = 1'b0;
    if (c >= 3000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: busy still %0b after %0d cycles", busy, c);
    end
    repeat (2) @(negedge clk);
    check("drained", 64'(acc_q.size() + out_q.size()), 64'd0);
    acc_q.delete();
    out_q.delete();
  endtask

  task automatic run_reset();
    int c;
    expect_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 200; c++) begin
      if (wb_cyc_o && wb_we_o && wb_adr_o == t_addr[2]) break;
      @(negedge clk);
    end
    if (c >= 200) begin
      checks++;
      errors++;
      $display("FAIL reset_wait: write to entry 2 never seen");
    end
    reset_n = 1'b0;
    acc_q.delete();
    out_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_mid", 64'({wb_cyc_o, wb_stb_o, busy, done, error, retry_cnt, wb_sel_o}), 64'd0);
    repeat (3) @(negedge clk);
    check("reset_idle", 64'({wb_cyc_o, busy}), 64'd0);
  endtask

  initial begin
    rand_table();
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, busy, done, error, err_code, err_index, retry_cnt}), 64'd0);
    check("reset_dat", 64'(wb_dat_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(0);
    t_mask[2] = '0;
    run(0);
    rand_table();
    t_mask[1] = 32'hFFFF;
    corrupt_idx = 1;
    corrupt_left = 1;
    run(0);
    corrupt_left = 100;
    run(0);
    corrupt_left = 0;
    nack_en = 1'b1;
    nack_idx = 3;
    run(0);
    nack_en = 1'b0;
    corrupt_left = 1;
    run(12);
    corrupt_left = 0;
    run_reset();
    run(0);
    for (int i = 0; i < N; i++) t_mask[i] = '0;
    run(0);
    for (int r = 0; r < 10; r++) begin
      rand_table();
      for (int i = 0; i < N; i++) t_mask[i] = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
      corrupt_idx = $urandom_range(N - 1);
      corrupt_left = $urandom_range(3);
      nack_en = $urandom_range(4) == 0;
      nack_idx = $urandom_range(N - 1);
      run($urandom_range(30));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
